// File: rtl/unsigned_mul_8x8_pkg.sv
// Shared definitions for the 8x8 approximate multiplier's half-adder reduce stage.
package unsigned_mul_8x8_pkg;

  localparam int unsigned HA_ROWS = 4;
  localparam int unsigned HA_B_W  = 7;
  localparam int unsigned HA_T_W  = 9;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned SUM_W   = 17;
  localparam int unsigned SHIFT_W = 3;

  // One half-adder-array row: t[k] sits at weight base+k, b[k] at base+k+2.
  typedef struct packed {
    logic [HA_B_W-1:0] b;
    logic [HA_T_W-1:0] t;
  } ha_row_t;

  // Base bit weight of row i is 2i.
  function automatic logic [SHIFT_W-1:0] row_base(input int unsigned row);
    return SHIFT_W'(2 * row);
  endfunction

endpackage

// File: rtl/ha_row_pair_add.sv
// Weighted sum of two adjacent ha_array rows; row_hi sits two bits above row_lo.
module ha_row_pair_add
  import unsigned_mul_8x8_pkg::*;
(
  input  ha_row_t              row_lo,
  input  ha_row_t              row_hi,
  input  logic [SHIFT_W-1:0]   base,
  output logic [SUM_W-1:0]     sum
);

  logic [SHIFT_W:0] sh0;
  logic [SHIFT_W:0] sh2;
  logic [SHIFT_W:0] sh4;

  // Shift amounts are widened so base+4 cannot wrap; the sum is kept at full
  // width so the upper pair (max 81520) is never truncated before stage 2.
  always_comb begin
    sh0 = {1'b0, base};
    sh2 = sh0 + (SHIFT_W+1)'(2);
    sh4 = sh0 + (SHIFT_W+1)'(4);
    sum = (SUM_W'(row_lo.t) << sh0)
        + (SUM_W'(row_lo.b) << sh2)
        + (SUM_W'(row_hi.t) << sh2)
        + (SUM_W'(row_hi.b) << sh4);
  end

endmodule

// File: rtl/unsigned_mul_8x8_ha_reduce.sv
// Two-stage elastic reduce of four ha_array rows into a 16-bit product with
// overflow saturation/wrap and a saturating overflow event counter.
module unsigned_mul_8x8_ha_reduce
  import unsigned_mul_8x8_pkg::*;
#(
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HA_B_W-1:0]    ha_array_0_b,
  input  logic [HA_B_W-1:0]    ha_array_1_b,
  input  logic [HA_B_W-1:0]    ha_array_2_b,
  input  logic [HA_B_W-1:0]    ha_array_3_b,
  input  logic [HA_T_W-1:0]    ha_array_0_t,
  input  logic [HA_T_W-1:0]    ha_array_1_t,
  input  logic [HA_T_W-1:0]    ha_array_2_t,
  input  logic [HA_T_W-1:0]    ha_array_3_t,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PROD_W-1:0]    prod,
  output logic                 prod_ovf,
  output logic [CNT_W-1:0]     ovf_cnt,
  input  logic                 ovf_cnt_clr
);

  ha_row_t            rows [HA_ROWS];
  logic [SUM_W-1:0]   pair_lo_sum;
  logic [SUM_W-1:0]   pair_hi_sum;

  logic               s1_valid_q, s1_valid_d;
  logic [SUM_W-1:0]   s1_a_q, s1_a_d;
  logic [SUM_W-1:0]   s1_b_q, s1_b_d;
  logic               out_valid_q, out_valid_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               prod_ovf_q, prod_ovf_d;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

  logic               s1_load;
  logic               s2_load;
  logic [SUM_W-1:0]   s_sum;

  // Gather the flat ports into row records.
  always_comb begin
    rows[0] = '{b: ha_array_0_b, t: ha_array_0_t};
    rows[1] = '{b: ha_array_1_b, t: ha_array_1_t};
    rows[2] = '{b: ha_array_2_b, t: ha_array_2_t};
    rows[3] = '{b: ha_array_3_b, t: ha_array_3_t};
  end

  ha_row_pair_add u_pair_lo (
    .row_lo (rows[0]),
    .row_hi (rows[1]),
    .base   (row_base(0)),
    .sum    (pair_lo_sum)
  );

  ha_row_pair_add u_pair_hi (
    .row_lo (rows[2]),
    .row_hi (rows[3]),
    .base   (row_base(2)),
    .sum    (pair_hi_sum)
  );

  // Handshake: s2 advances when it is empty or being drained; s1 refills behind it.
  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    s1_load  = in_valid && in_ready;
  end

  // Next-state for both pipeline stages and the overflow counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    prod_ovf_d  = prod_ovf_q;
    ovf_cnt_d   = ovf_cnt_q;
    s_sum       = s1_a_q + s1_b_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_a_d     = pair_lo_sum;
      s1_b_d     = pair_hi_sum;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      prod_ovf_d  = s_sum[SUM_W-1];
      prod_d      = (s_sum[SUM_W-1] && SATURATE) ? '1 : s_sum[PROD_W-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (ovf_cnt_clr) begin
      ovf_cnt_d = '0;
    end else if (out_valid_q && out_ready && prod_ovf_q && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      prod_ovf_q  <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
      prod_ovf_q  <= prod_ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  // Stage-1 data registers; they only change on an accepted input.
  always_ff @(posedge clk) begin
    s1_a_q <= s1_a_d;
    s1_b_q <= s1_b_d;
  end

  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign prod_ovf  = prod_ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_reduce.sv
// Directed bench: table of row vectors with hand-computed products, plus
// sequences for backpressure, mid-flight reset, counter clear and saturation.
module tb_unsigned_mul_8x8_ha_reduce;

  typedef struct packed {
    logic [3:0][6:0] b;
    logic [3:0][8:0] t;
    logic [15:0]     exp_prod;
    logic [15:0]     exp_wrap;
    logic            exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, ovf_cnt_clr;
  logic [6:0]  b0, b1, b2, b3;
  logic [8:0]  t0, t1, t2, t3;
  logic        in_ready, out_valid, prod_ovf;
  logic [15:0] prod;
  logic [15:0] ovf_cnt;
  logic        in_ready_w, out_valid_w, prod_ovf_w;
  logic [15:0] prod_w;
  logic [1:0]  ovf_cnt_w;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  unsigned_mul_8x8_ha_reduce #(.SATURATE(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(b0), .ha_array_1_b(b1), .ha_array_2_b(b2), .ha_array_3_b(b3),
    .ha_array_0_t(t0), .ha_array_1_t(t1), .ha_array_2_t(t2), .ha_array_3_t(t3),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .prod_ovf(prod_ovf),
    .ovf_cnt(ovf_cnt), .ovf_cnt_clr(ovf_cnt_clr)
  );

  unsigned_mul_8x8_ha_reduce #(.SATURATE(1'b0), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .ha_array_0_b(b0), .ha_array_1_b(b1), .ha_array_2_b(b2), .ha_array_3_b(b3),
    .ha_array_0_t(t0), .ha_array_1_t(t1), .ha_array_2_t(t2), .ha_array_3_t(t3),
    .out_valid(out_valid_w), .out_ready(out_ready), .prod(prod_w), .prod_ovf(prod_ovf_w),
    .ovf_cnt(ovf_cnt_w), .ovf_cnt_clr(ovf_cnt_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_rows(input vec_t v);
    b0 = v.b[0]; b1 = v.b[1]; b2 = v.b[2]; b3 = v.b[3];
    t0 = v.t[0]; t1 = v.t[1]; t2 = v.t[2]; t3 = v.t[3];
  endtask

  // Presents one beat, then returns at the negedge where out_valid is first seen.
  task automatic send_one(input vec_t v, output int unsigned lat);
    int unsigned guard;
    @(negedge clk);
    set_rows(v);
    in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t        vecs [9];
  vec_t        ones;
  vec_t        bp;
  int unsigned lat;
  int unsigned n_ovf;
  int unsigned nxt;
  int unsigned got;
  int unsigned cyc;
  logic        acc;
  logic        gap;
  logic        seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_cnt_clr = 1'b0;
    b0 = '0; b1 = '0; b2 = '0; b3 = '0;
    t0 = '0; t1 = '0; t2 = '0; t3 = '0;

    vecs[0] = '0;
    vecs[1] = '0; vecs[1].t[0] = 9'h001; vecs[1].exp_prod = 16'd1;     vecs[1].exp_wrap = 16'd1;
    vecs[2] = '0; vecs[2].b[3] = 7'h40;  vecs[2].exp_prod = 16'd16384; vecs[2].exp_wrap = 16'd16384;
    vecs[3] = '0; vecs[3].b[1] = 7'h01;  vecs[3].exp_prod = 16'd16;    vecs[3].exp_wrap = 16'd16;
    vecs[4] = '0; vecs[4].t[2] = 9'h1FF; vecs[4].exp_prod = 16'd8176;  vecs[4].exp_wrap = 16'd8176;
    vecs[5] = '0; vecs[5].b[0] = 7'h7F; vecs[5].t[1] = 9'h100;
    vecs[5].exp_prod = 16'd1532; vecs[5].exp_wrap = 16'd1532;
    vecs[6] = '1; vecs[6].exp_prod = 16'hFFFF; vecs[6].exp_wrap = 16'd21079; vecs[6].exp_ovf = 1'b1;
    vecs[7] = '0; vecs[7].t[3] = 9'h1FF; vecs[7].b[3] = 7'h7F;
    vecs[7].exp_prod = 16'd65216; vecs[7].exp_wrap = 16'd65216;
    vecs[8] = '0; vecs[8].t[3] = 9'h1FF; vecs[8].b[3] = 7'h7F; vecs[8].t[2] = 9'h1FF;
    vecs[8].exp_prod = 16'hFFFF; vecs[8].exp_wrap = 16'd7856; vecs[8].exp_ovf = 1'b1;
    ones = vecs[6];

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_prod", prod, 0);
    chk("rst_prod_ovf", prod_ovf, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);

    n_ovf = 0;
    for (int unsigned i = 0; i < 9; i++) begin
      send_one(vecs[i], lat);
      chk($sformatf("latency[%0d]", i), lat, 2);
      chk($sformatf("prod[%0d]", i), prod, vecs[i].exp_prod);
      chk($sformatf("prod_ovf[%0d]", i), prod_ovf, vecs[i].exp_ovf);
      chk($sformatf("prod_wrap[%0d]", i), prod_w, vecs[i].exp_wrap);
      chk($sformatf("prod_ovf_wrap[%0d]", i), prod_ovf_w, vecs[i].exp_ovf);
      if (vecs[i].exp_ovf) n_ovf++;
    end
    @(negedge clk);
    chk("table_ovf_cnt", ovf_cnt, n_ovf);
    chk("table_ovf_cnt_w", ovf_cnt_w, n_ovf);

    // Backpressure: four beats 1..4, consumer stalled for 5 cycles.
    out_ready = 1'b0;
    nxt = 1;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      if (nxt <= 4) begin
        bp = '0; bp.t[0] = 9'(nxt); set_rows(bp); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) chk("stall_prod", prod, 1);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) nxt++;
    end
    @(negedge clk);
    chk("bp_accepts", nxt - 1, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_prod_hold", prod, 1);
    out_ready = 1'b1;
    got = 0; cyc = 0; gap = 1'b0;
    while (got < 4 && cyc < 20) begin
      if (nxt <= 4) begin
        bp = '0; bp.t[0] = 9'(nxt); set_rows(bp); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        chk("bp_order", prod, got + 1);
        got++;
      end else if (got > 0) begin
        gap = 1'b1;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) nxt++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_count", got, 4);
    chk("bp_gap", gap, 0);

    // Reset with two beats in flight and a third presented during reset.
    bp = '0; bp.t[0] = 9'd5; set_rows(bp); in_valid = 1'b1;
    @(negedge clk);
    bp.t[0] = 9'd6; set_rows(bp);
    @(negedge clk);
    bp.t[0] = 9'd7; set_rows(bp); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_prod", prod, 0);
    chk("midrst_ovf_cnt", ovf_cnt, 0);
    chk("midrst_ovf_cnt_w", ovf_cnt_w, 0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_output", seen, 0);

    // One overflow delivery counts once.
    send_one(ones, lat);
    @(negedge clk);
    chk("ovf_cnt_one", ovf_cnt, 1);

    // Clear wins over a same-cycle overflow transfer.
    out_ready = 1'b0;
    send_one(ones, lat);
    chk("clr_held_ovf", prod_ovf, 1);
    ovf_cnt_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    ovf_cnt_clr = 1'b0;
    chk("clr_priority", ovf_cnt, 0);
    chk("clr_priority_w", ovf_cnt_w, 0);
    chk("clr_drained", out_valid, 0);

    // Counter sticks at all-ones (the 2-bit instance saturates at 3).
    repeat (4) send_one(ones, lat);
    @(negedge clk);
    chk("sat_cnt", ovf_cnt, 4);
    chk("sat_cnt_w", ovf_cnt_w, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
